// File: rtl/reaction_responder_pkg.sv
// Shared types and constants for the reaction-timer synthetic player.
package reaction_responder_pkg;

    // Trial sequencer states
    typedef enum logic [2:0] {
        IDLE,
        START,
        GAP,
        WAIT_LED,
        REACT,
        STOP,
        FIN
    } state_t;

    // Game buttons are active-low
    localparam logic BTN_PRESSED  = 1'b0;
    localparam logic BTN_RELEASED = 1'b1;

    // One tick_1k pulse marks one millisecond
    localparam int unsigned TICKS_PER_MS = 1;

    // Bit 1 is START/STOP, bit 0 (game reset) is never pressed
    function automatic logic [1:0] button_word(input logic start_stop_low);
        return {(start_stop_low ? BTN_PRESSED : BTN_RELEASED), BTN_RELEASED};
    endfunction

endpackage

// File: rtl/reaction_responder_if.sv
// Trial control and game-facing signals of the reaction responder.
interface reaction_responder_if #(
    parameter int unsigned DW = 12
) ();
    logic          arm;
    logic [DW-1:0] delay_ms;
    logic          led;
    logic [1:0]    button;
    logic          busy;
    logic          done;
    logic          timeout;

    // Controller / game side
    modport master (
        output arm, delay_ms, led,
        input  button, busy, done, timeout
    );

    // Responder side
    modport slave (
        input  arm, delay_ms, led,
        output button, busy, done, timeout
    );
endinterface

// File: rtl/reaction_responder_press_gen.sv
// Press-width generator: a go pulse yields a low pulse of PRESS_CYCLES cycles.
module reaction_responder_press_gen #(
    parameter int unsigned PRESS_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic go_i,
    output logic low_o,
    output logic last_o
);
    localparam int unsigned CW = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;

    logic [CW-1:0] cnt_q;
    logic          low_q;

    // Hold the press for PRESS_CYCLES cycles starting the cycle after go
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            low_q <= 1'b0;
            cnt_q <= '0;
        end else if (go_i) begin
            low_q <= 1'b1;
            cnt_q <= CW'(PRESS_CYCLES - 1);
        end else if (low_q) begin
            if (cnt_q == '0) begin
                low_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign low_o  = low_q;
    assign last_o = low_q && (cnt_q == '0);
endmodule

// File: rtl/reaction_responder.sv
// Synthetic reaction-timer player: press START, wait for the LED, wait
// delay_ms ticks, press STOP. Reports done, busy and a sticky timeout.
module reaction_responder
    import reaction_responder_pkg::*;
#(
    parameter int unsigned DW           = 12,
    parameter int unsigned PRESS_CYCLES = 4,
    parameter int unsigned TIMEOUT_MS   = 4000,
    parameter int unsigned GAP_CYCLES   = 2
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 tick_1k,
    reaction_responder_if.slave  bus
);
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t        state_q;
    logic          led_q;
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] dly_q;
    logic [GW-1:0] gap_q;
    logic          busy_q;
    logic          done_q;
    logic          timeout_q;

    logic          rise;
    logic [DW-1:0] cnt_inc;
    logic          accept;
    logic          stop_go;
    logic          press_go;
    logic          press_low;
    logic          press_last;

    // The press generator must start on the same edge the FSM changes
    // state, so its go is decoded from the current state and inputs.
    always_comb begin
        rise     = bus.led & ~led_q;
        cnt_inc  = cnt_q + DW'(1);
        accept   = (state_q == IDLE) && bus.arm;
        stop_go  = ((state_q == WAIT_LED) && rise && (dly_q == '0)) ||
                   ((state_q == REACT) && tick_1k && (cnt_inc == dly_q));
        press_go = accept || stop_go;
    end

    reaction_responder_press_gen #(
        .PRESS_CYCLES(PRESS_CYCLES)
    ) u_press (
        .clk_i (Clk),
        .rst_i (reset),
        .go_i  (press_go),
        .low_o (press_low),
        .last_o(press_last)
    );

    // Trial sequencer with registered busy/done/timeout
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= IDLE;
            led_q     <= 1'b0;
            cnt_q     <= '0;
            dly_q     <= '0;
            gap_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            led_q  <= bus.led;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        dly_q     <= bus.delay_ms;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (press_last) begin
                        gap_q   <= '0;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    if (gap_q == GW'(GAP_CYCLES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_LED;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                WAIT_LED: begin
                    if (rise) begin
                        cnt_q   <= '0;
                        state_q <= (dly_q == '0) ? STOP : REACT;
                    end else if (tick_1k) begin
                        if (cnt_inc == DW'(TIMEOUT_MS)) begin
                            timeout_q <= 1'b1;
                            done_q    <= 1'b1;
                            state_q   <= FIN;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                REACT: begin
                    if (tick_1k) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == dly_q) begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (press_last) begin
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.button  = button_word(press_low);
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_reaction_responder.sv
// Directed bench for reaction_responder with a press/done scoreboard.
module tb_reaction_responder;

    localparam int unsigned DW      = 12;
    localparam int unsigned TMO     = 400;
    localparam int          TPERIOD = 4;

    typedef struct {
        int at;
        int val;
    } exp_t;

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic tick_1k = 1'b0;
    int   cyc     = 0;

    int   errors  = 0;
    int   checks  = 0;

    exp_t press_q[$];
    exp_t done_q[$];
    exp_t pe;
    exp_t de;
    int   run_start = 0;
    int   run_len   = 0;

    reaction_responder_if #(.DW(DW)) bus ();

    reaction_responder #(
        .DW          (DW),
        .PRESS_CYCLES(4),
        .TIMEOUT_MS  (TMO),
        .GAP_CYCLES  (2)
    ) dut (
        .Clk    (clk),
        .reset  (reset),
        .tick_1k(tick_1k),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Ticks are sampled on edges whose number is a multiple of TPERIOD
    always @(negedge clk) tick_1k = ((cyc % TPERIOD) == TPERIOD - 1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int first_tick(input int edge_no);
        return (edge_no / TPERIOD + 1) * TPERIOD;
    endfunction

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic trial_arm(input int d, output int k);
        bus.arm      = 1'b1;
        bus.delay_ms = DW'(d);
        k            = cyc;
        press_q.push_back('{k + 1, 4});
        @(negedge clk);
        bus.arm = 1'b0;
        chk("busy_on_arm", bus.busy, 1);
        chk("start_low_on_arm", bus.button, 2'b01);
    endtask

    task automatic pulse_arm();
        bus.arm      = 1'b1;
        bus.delay_ms = DW'(7);
        @(negedge clk);
        bus.arm = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, bus.done, 1);
    endtask

    // Monitor: pops expectations as presses finish and done pulses appear
    always @(negedge clk) begin
        if (bus.button[1] === 1'b0) begin
            if (run_len == 0) run_start = cyc;
            run_len++;
        end else if (run_len > 0) begin
            if (press_q.size() == 0) begin
                chk("press_unexpected", 32'(press_q.size()), 1);
            end else begin
                pe = press_q.pop_front();
                chk("press_start", run_start, pe.at);
                chk("press_len", run_len, pe.val);
                chk("button0_high", bus.button[0], 1);
            end
            run_len = 0;
        end
        if (bus.done === 1'b1) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 32'(done_q.size()), 1);
            end else begin
                de = done_q.pop_front();
                chk("done_cycle", cyc, de.at);
                chk("done_timeout", bus.timeout, de.val);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r;
        int t;
        bus.arm      = 1'b0;
        bus.delay_ms = '0;
        bus.led      = 1'b0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_button", bus.button, 2'b11);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_timeout", bus.timeout, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Trial A: delay 250, LED after ~300 ticks, ignored arms throughout
        trial_arm(250, k);
        pulse_arm();
        wait_until(k + 5);
        pulse_arm();
        wait_until(k + 40);
        pulse_arm();
        wait_until(k + 1200);
        bus.led = 1'b1;
        r = cyc;
        t = first_tick(r + 1) + TPERIOD * (250 - 1);
        press_q.push_back('{t, 4});
        done_q.push_back('{t + 4, 0});
        wait_until(r + 50);
        pulse_arm();
        wait_until(r + 100);
        bus.led = 1'b0;
        wait_done(1100, "a_done_seen");
        chk("a_busy_at_done", bus.busy, 1);
        @(negedge clk);
        chk("a_busy_after_done", bus.busy, 0);
        chk("a_done_one_cycle", bus.done, 0);
        repeat (3) @(negedge clk);

        // Trial B: delay 0, STOP press right after the rise
        trial_arm(0, k);
        wait_until(k + 20);
        bus.led = 1'b1;
        r = cyc;
        press_q.push_back('{r + 1, 4});
        done_q.push_back('{r + 5, 0});
        wait_done(50, "b_done_seen");
        bus.led = 1'b0;
        repeat (3) @(negedge clk);

        // Trial C: LED already high, no fresh edge -> timeout
        bus.led = 1'b1;
        repeat (2) @(negedge clk);
        trial_arm(5, k);
        t = first_tick(k + 7) + TPERIOD * (TMO - 1);
        done_q.push_back('{t, 1});
        wait_done(TMO * TPERIOD + 100, "c_done_seen");
        repeat (3) @(negedge clk);
        chk("c_timeout_sticky", bus.timeout, 1);
        chk("c_no_stop_press", bus.button, 2'b11);
        bus.led = 1'b0;
        repeat (2) @(negedge clk);

        // Trial D: reset in the middle of the STOP press
        trial_arm(2, k);
        chk("d_timeout_cleared", bus.timeout, 0);
        wait_until(k + 20);
        bus.led = 1'b1;
        r = cyc;
        t = first_tick(r + 1) + TPERIOD;
        press_q.push_back('{t, 2});
        wait_until(t + 1);
        reset = 1'b1;
        @(negedge clk);
        chk("d_rst_button", bus.button, 2'b11);
        chk("d_rst_busy", bus.busy, 0);
        chk("d_rst_done", bus.done, 0);
        reset   = 1'b0;
        bus.led = 1'b0;
        repeat (3) @(negedge clk);

        // Trial E: normal trial after the mid-press reset
        trial_arm(5, k);
        wait_until(k + 20);
        bus.led = 1'b1;
        r = cyc;
        t = first_tick(r + 1) + TPERIOD * (5 - 1);
        press_q.push_back('{t, 4});
        done_q.push_back('{t + 4, 0});
        wait_done(100, "e_done_seen");
        bus.led = 1'b0;

        repeat (10) @(negedge clk);
        chk("press_queue_drained", 32'(press_q.size()), 0);
        chk("done_queue_drained", 32'(done_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
